// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder and the ALU status register.
// Flag bit positions and the 4-bit flags word are common to both.
package adder_pkg;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned NUM_FLAGS = 4;

  typedef logic [NUM_FLAGS-1:0] flags_t;

  function automatic flags_t pack_flags(input logic c, input logic v, input logic z,
                                        input logic n);
    flags_t f;
    f = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational WIDTH-bit adder slice used once per pipeline stage.
// Also reports the carry into its MSB so the top slice can form signed overflow.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [WIDTH:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sum   = total[WIDTH-1:0];
    cout  = total[WIDTH];
    // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ total[WIDTH-1];
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one carry chunk per stage, valid/ready handshake with
// a single global advance, status flags formed in the final stage.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  logic             adv;
  logic             valid_q [STAGES];
  // acc_q holds finished sum chunks below the stage index and raw A chunks above it.
  logic [WIDTH-1:0] acc_q   [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             carry_q [STAGES];
  logic             c_msb   [STAGES];
  flags_t           flags_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic             valid_in;
    logic [WIDTH-1:0] acc_d;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    if (k == 0) begin : g_first
      // Subtraction as A + ~B + ~borrow.
      assign acc_in   = a;
      assign b_in     = sub ? ~b : b;
      assign carry_in = sub ? ~cin : cin;
      assign valid_in = in_valid;
    end else begin : g_rest
      assign acc_in   = acc_q[k-1];
      assign b_in     = b_q[k-1];
      assign carry_in = carry_q[k-1];
      assign valid_in = valid_q[k-1];
    end

    adder_chunk #(
      .WIDTH(CHUNK)
    ) u_chunk (
      .a    (acc_in[k*CHUNK +: CHUNK]),
      .b    (b_in[k*CHUNK +: CHUNK]),
      .cin  (carry_in),
      .sum  (chunk_sum),
      .cout (chunk_cout),
      .c_msb(c_msb[k])
    );

    always_comb begin
      acc_d                    = acc_in;
      acc_d[k*CHUNK +: CHUNK]  = chunk_sum;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q[k] <= 1'b0;
        acc_q[k]   <= '0;
        b_q[k]     <= '0;
        carry_q[k] <= 1'b0;
      end else if (adv) begin
        valid_q[k] <= valid_in;
        acc_q[k]   <= acc_d;
        b_q[k]     <= b_in;
        carry_q[k] <= chunk_cout;
      end
    end

    if (k == STAGES - 1) begin : g_flags
      always_ff @(posedge clk) begin
        if (reset) begin
          flags_q <= '0;
        end else if (adv) begin
          flags_q <= pack_flags(chunk_cout, c_msb[k] ^ chunk_cout, acc_d == '0,
                                acc_d[WIDTH-1]);
        end
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = flags_q[FLAG_C];
  assign overflow  = flags_q[FLAG_V];
  assign zero      = flags_q[FLAG_Z];
  assign negative  = flags_q[FLAG_N];

endmodule
